// File: rtl/checker_phy_n.sv
// Lane-by-lane comparator between a conductual and an estructural PHY model.
// Aligns the conductual stream by a programmable skew, counts mismatches and captures the first one.
module checker_phy_n #(
  parameter int  DATA_W   = 8,
  parameter int  LANES    = 2,
  parameter int  MAX_SKEW = 7,
  parameter int  CNT_W    = 16,
  localparam int SKEW_W   = $clog2(MAX_SKEW + 1),
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int BUS_W    = LANES * DATA_W
) (
  input  logic                   clk_8f,
  input  logic                   reset_L,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [SKEW_W-1:0]      skew,
  input  logic [BUS_W-1:0]       data_c,
  input  logic [BUS_W-1:0]       data_e,
  output logic [LANES-1:0]       check_out,
  output logic [LANES-1:0]       err_sticky,
  output logic [LANES*CNT_W-1:0] err_count,
  output logic                   first_err_valid,
  output logic [LANE_W-1:0]      first_err_lane,
  output logic [DATA_W-1:0]      first_err_c,
  output logic [DATA_W-1:0]      first_err_e,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            st;
  logic [BUS_W-1:0]  reg_c;
  logic [BUS_W-1:0]  reg_e;
  logic [BUS_W-1:0]  tap;
  logic [BUS_W-1:0]  dline [MAX_SKEW];
  logic [SKEW_W-1:0] eff_skew;
  logic [SKEW_W-1:0] skew_q;
  logic [SKEW_W-1:0] fill_cnt;
  logic [LANES-1:0]  mism;
  logic [LANES-1:0]  hit;
  logic              active;
  logic              skew_chg;
  logic [LANE_W-1:0] cap_lane;
  logic [DATA_W-1:0] cap_c;
  logic [DATA_W-1:0] cap_e;

  // Out-of-range skew codes only exist when the port has spare encodings.
  if (((1 << SKEW_W) - 1) > MAX_SKEW) begin : g_clamp
    assign eff_skew = (skew > SKEW_W'(MAX_SKEW)) ? SKEW_W'(MAX_SKEW) : skew;
  end else begin : g_noclamp
    assign eff_skew = skew;
  end

  assign skew_chg = (eff_skew != skew_q);
  assign state    = st;

  // Input capture and alignment delay line; runs in every state so history is
  // already valid when checking starts.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      reg_c <= '0;
      reg_e <= '0;
      // NOTE: the delay line is reset on purpose: a reset must discard all
      // history, so each stage is cleared rather than left as free-running storage.
      for (int j = 0; j < MAX_SKEW; j++) dline[j] <= '0;
    end else begin
      reg_c    <= data_c;
      reg_e    <= data_e;
      dline[0] <= reg_c;
      for (int j = 1; j < MAX_SKEW; j++) dline[j] <= dline[j-1];
    end
  end

  always_comb begin
    // NOTE: default assignment first so every path drives tap and no latch is inferred.
    tap = reg_c;
    for (int j = 0; j < MAX_SKEW; j++) begin
      if (int'(eff_skew) == j + 1) tap = dline[j];
    end
  end

  // Per-lane compare and lowest-index mismatch selection.
  always_comb begin
    mism     = '0;
    cap_lane = '0;
    cap_c    = '0;
    cap_e    = '0;
    for (int i = 0; i < LANES; i++) begin
      mism[i] = (tap[i*DATA_W +: DATA_W] != reg_e[i*DATA_W +: DATA_W]);
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mism[i]) begin
        cap_lane = LANE_W'(i);
        cap_c    = tap[i*DATA_W +: DATA_W];
        cap_e    = reg_e[i*DATA_W +: DATA_W];
      end
    end
  end

  // A skew change or enable drop on this edge leaves CHECK, so nothing is scored.
  assign active = (st == CHECK) && enable && !skew_chg;
  assign hit    = active ? mism : '0;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      st       <= IDLE;
      fill_cnt <= '0;
      skew_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      skew_q <= eff_skew;
      if (!enable) begin
        st <= IDLE;
      end else begin
        case (st)
          IDLE: begin
            st       <= FILL;
            fill_cnt <= '0;
          end
          FILL: begin
            if (skew_chg) begin
              fill_cnt <= '0;
            end else if (fill_cnt == eff_skew) begin
              st <= CHECK;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          CHECK: begin
            if (skew_chg) begin
              st       <= FILL;
              fill_cnt <= '0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      check_out       <= '1;
      err_sticky      <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_lane  <= '0;
      first_err_c     <= '0;
      first_err_e     <= '0;
    end else begin
      check_out <= ~hit;
      if (clear) begin
        err_sticky      <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_lane  <= '0;
        first_err_c     <= '0;
        first_err_e     <= '0;
      end else begin
        err_sticky <= err_sticky | hit;
        for (int i = 0; i < LANES; i++) begin
          if (hit[i] && (err_count[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
            err_count[i*CNT_W +: CNT_W] <= err_count[i*CNT_W +: CNT_W] + 1'b1;
          end
        end
        if (!first_err_valid && (|hit)) begin
          first_err_valid <= 1'b1;
          first_err_lane  <= cap_lane;
          first_err_c     <= cap_c;
          first_err_e     <= cap_e;
        end
      end
    end
  end

endmodule

// File: tb/tb_checker_phy_n.sv
// Self-checking bench for checker_phy_n: directed vector table, corner sequences,
// and random traffic scored against a history-based reference model.
module tb_checker_phy_n;

  localparam int DW = 8;
  localparam int LN = 2;
  localparam int MS = 7;
  localparam int SW = 3;
  localparam int BW = LN * DW;

  logic          clk_8f = 1'b0;
  logic          reset_L;
  logic          enable;
  logic          clear;
  logic [SW-1:0] skew;
  logic [BW-1:0] data_c;
  logic [BW-1:0] data_e;

  logic [LN-1:0]    check_out, err_sticky;
  logic [LN*16-1:0] err_count;
  logic             first_err_valid;
  logic [0:0]       first_err_lane;
  logic [DW-1:0]    first_err_c, first_err_e;
  logic [1:0]       state;

  logic [LN-1:0]    co4, sticky4;
  logic [LN*4-1:0]  cnt4;
  logic             fv4;
  logic [0:0]       fl4;
  logic [DW-1:0]    fc4, fe4;
  logic [1:0]       st4;

  checker_phy_n #(.DATA_W(DW), .LANES(LN), .MAX_SKEW(MS), .CNT_W(16)) dut (
    .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable), .clear(clear), .skew(skew),
    .data_c(data_c), .data_e(data_e), .check_out(check_out), .err_sticky(err_sticky),
    .err_count(err_count), .first_err_valid(first_err_valid), .first_err_lane(first_err_lane),
    .first_err_c(first_err_c), .first_err_e(first_err_e), .state(state)
  );

  checker_phy_n #(.DATA_W(DW), .LANES(LN), .MAX_SKEW(MS), .CNT_W(4)) dut4 (
    .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable), .clear(clear), .skew(skew),
    .data_c(data_c), .data_e(data_e), .check_out(co4), .err_sticky(sticky4),
    .err_count(cnt4), .first_err_valid(fv4), .first_err_lane(fl4),
    .first_err_c(fc4), .first_err_e(fe4), .state(st4)
  );

  always #5 clk_8f = ~clk_8f;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw sample history plus the cycle at which filling began.
  logic [BW-1:0] hist_c[$];
  logic [BW-1:0] hist_e[$];
  bit            m_active;
  int            m_fill_start, m_prev_eff, m_state;
  logic [LN-1:0] m_check, m_sticky;
  int            m_cnt [LN];
  bit            m_fv;
  int            m_fl;
  logic [DW-1:0] m_fc, m_fe;

  function automatic void model_reset();
    hist_c.delete();
    hist_e.delete();
    m_active = 0; m_fill_start = 0; m_prev_eff = 0; m_state = 0;
    m_check = '1; m_sticky = '0;
    for (int i = 0; i < LN; i++) m_cnt[i] = 0;
    m_fv = 0; m_fl = 0; m_fc = '0; m_fe = '0;
  endfunction

  function automatic logic [BW-1:0] hist_at(input bit c_side, input int idx);
    if (idx < 0 || idx >= hist_c.size()) return '0;
    return c_side ? hist_c[idx] : hist_e[idx];
  endfunction

  function automatic void model_step(input logic en, input logic clr, input logic [SW-1:0] sk,
                                     input logic [BW-1:0] dc, input logic [BW-1:0] de);
    int            eff;
    int            n;
    bit            checking;
    bit            found;
    logic [BW-1:0] cw, ew;
    logic [LN-1:0] mism;
    eff      = int'(sk);
    n        = hist_c.size();
    checking = (m_state == 2) && en && (eff == m_prev_eff);
    cw       = hist_at(1, n - 1 - eff);
    ew       = hist_at(0, n - 1);
    mism     = '0;
    if (checking)
      for (int i = 0; i < LN; i++) mism[i] = (cw[i*DW +: DW] != ew[i*DW +: DW]);
    m_check = ~mism;
    if (clr) begin
      m_sticky = '0;
      for (int i = 0; i < LN; i++) m_cnt[i] = 0;
      m_fv = 0; m_fl = 0; m_fc = '0; m_fe = '0;
    end else begin
      found = 0;
      for (int i = 0; i < LN; i++) begin
        if (mism[i]) begin
          m_sticky[i] = 1'b1;
          m_cnt[i]++;
          if (!m_fv && !found) begin
            found = 1; m_fl = i; m_fc = cw[i*DW +: DW]; m_fe = ew[i*DW +: DW];
          end
        end
      end
      if (found) m_fv = 1;
    end
    if (!en) m_active = 0;
    else begin
      if (!m_active || eff != m_prev_eff) m_fill_start = n;
      m_active = 1;
    end
    m_state    = !m_active ? 0 : ((n - m_fill_start <= eff) ? 1 : 2);
    m_prev_eff = eff;
    hist_c.push_back(dc);
    hist_e.push_back(de);
  endfunction

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("check_out", 32'(check_out), 32'(m_check));
    check("check_out_cnt4", 32'(co4), 32'(m_check));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    for (int i = 0; i < LN; i++) begin
      check($sformatf("err_count16[%0d]", i), 32'(err_count[i*16 +: 16]),
            (m_cnt[i] > 65535) ? 32'd65535 : 32'(m_cnt[i]));
      check($sformatf("err_count4[%0d]", i), 32'(cnt4[i*4 +: 4]),
            (m_cnt[i] > 15) ? 32'd15 : 32'(m_cnt[i]));
    end
    check("first_err_valid", 32'(first_err_valid), 32'(m_fv));
    check("first_err_lane", 32'(first_err_lane), 32'(m_fl));
    check("first_err_c", 32'(first_err_c), 32'(m_fc));
    check("first_err_e", 32'(first_err_e), 32'(m_fe));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_check_out"}, 32'(check_out), 32'h3);
    check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
    check({tag, "_count"}, 32'(err_count), 32'd0);
    check({tag, "_count4"}, 32'(cnt4), 32'd0);
    check({tag, "_fvalid"}, 32'(first_err_valid), 32'd0);
    check({tag, "_flane"}, 32'(first_err_lane), 32'd0);
    check({tag, "_fc"}, 32'(first_err_c), 32'd0);
    check({tag, "_fe"}, 32'(first_err_e), 32'd0);
  endtask

  task automatic step(input logic en, input logic clr, input logic [SW-1:0] sk,
                      input logic [BW-1:0] dc, input logic [BW-1:0] de);
    @(negedge clk_8f);
    enable = en; clear = clr; skew = sk; data_c = dc; data_e = de;
    @(posedge clk_8f);
    model_step(en, clr, sk, dc, de);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic        en;
    logic        clr;
    logic [2:0]  sk;
    logic [15:0] dc;
    logic [15:0] de;
    logic [1:0]  st;
    logic [1:0]  co;
    logic [1:0]  sticky;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic        fv;
    logic        fl;
    logic [7:0]  fc;
    logic [7:0]  fe;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [BW-1:0] stream(input int t);
    logic [7:0] lo, hi;
    lo = 8'(t);
    hi = 8'(t + 8'h40);
    return {hi, lo};
  endfunction

  initial begin
    logic [SW-1:0] rsk;
    logic [BW-1:0] dc, de, src;
    int            n;
    logic          ren, rclr;

    //               en clr sk  dc        de        st    co     stk    cnt0   cnt1   fv fl fc     fe
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 2'd1, 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 16'h1111, 16'h1111, 2'd2, 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 16'h2222, 16'h2222, 2'd2, 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 16'hA533, 16'h5A33, 2'd2, 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 3'd0, 16'h4444, 16'h4444, 2'd2, 2'b01, 2'b10, 16'd0, 16'd1, 1'b1, 1'b1, 8'hA5, 8'h5A};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 16'h55C3, 16'h553C, 2'd2, 2'b11, 2'b10, 16'd0, 16'd1, 1'b1, 1'b1, 8'hA5, 8'h5A};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 16'h66FF, 16'h6600, 2'd2, 2'b10, 2'b11, 16'd1, 16'd1, 1'b1, 1'b1, 8'hA5, 8'h5A};
    tbl[7]  = '{1'b1, 1'b1, 3'd0, 16'h7777, 16'h7777, 2'd2, 2'b10, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 3'd0, 16'h8888, 16'h8888, 2'd2, 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 16'h9999, 16'h9999, 2'd0, 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 16'hAAAA, 16'hAAAA, 2'd0, 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 8'h00, 8'h00};

    enable = 0; clear = 0; skew = '0; data_c = '0; data_e = '0;
    reset_L = 1'b1;
    #1 reset_L = 1'b0;
    repeat (2) @(posedge clk_8f);
    #1 check_reset_vals("reset");
    @(negedge clk_8f);
    reset_L = 1'b1;
    model_reset();

    // Directed table: fill, single lane-1 corruption, lane-0 error, clear vs mismatch, disable.
    for (int v = 0; v < 11; v++) begin
      step(tbl[v].en, tbl[v].clr, tbl[v].sk, tbl[v].dc, tbl[v].de);
      check($sformatf("tbl%0d_state", v), 32'(state), 32'(tbl[v].st));
      check($sformatf("tbl%0d_check_out", v), 32'(check_out), 32'(tbl[v].co));
      check($sformatf("tbl%0d_sticky", v), 32'(err_sticky), 32'(tbl[v].sticky));
      check($sformatf("tbl%0d_cnt0", v), 32'(err_count[15:0]), 32'(tbl[v].cnt0));
      check($sformatf("tbl%0d_cnt1", v), 32'(err_count[31:16]), 32'(tbl[v].cnt1));
      check($sformatf("tbl%0d_fvalid", v), 32'(first_err_valid), 32'(tbl[v].fv));
      check($sformatf("tbl%0d_flane", v), 32'(first_err_lane), 32'(tbl[v].fl));
      check($sformatf("tbl%0d_fc", v), 32'(first_err_c), 32'(tbl[v].fc));
      check($sformatf("tbl%0d_fe", v), 32'(first_err_e), 32'(tbl[v].fe));
    end

    // Continuous lane-0 mismatch: 22 scored cycles, 4-bit counter must stick at 15.
    for (int t = 0; t < 24; t++) step(1'b1, 1'b0, 3'd0, 16'h2211, 16'h22EE);
    check("sat_cnt4_lane0", 32'(cnt4[3:0]), 32'd15);
    check("sat_cnt16_lane0", 32'(err_count[15:0]), 32'd22);
    check("sat_cnt16_lane1", 32'(err_count[31:16]), 32'd0);

    // Estructural stream lags by 3: clean at skew 3, both lanes fail at skew 2.
    for (int t = 0; t < 16; t++) step(1'b1, (t == 0), 3'd3, stream(t), stream(t - 3));
    check("skew3_cnt0", 32'(err_count[15:0]), 32'd0);
    check("skew3_cnt1", 32'(err_count[31:16]), 32'd0);
    check("skew3_check_out", 32'(check_out), 32'h3);
    for (int t = 16; t < 28; t++) step(1'b1, 1'b0, 3'd2, stream(t), stream(t - 3));
    check("skew2_cnt0", 32'(err_count[15:0]), 32'd8);
    check("skew2_cnt1", 32'(err_count[31:16]), 32'd8);
    check("skew2_check_out", 32'(check_out), 32'h0);

    // Reset pulse between edges while in CHECK.
    #2 reset_L = 1'b0;
    #1 check_reset_vals("midrst");
    #1 reset_L = 1'b1;
    #0 check("midrst_release_state", 32'(state), 32'd0);
    model_reset();

    // Random traffic, mostly aligned so checking phases run long enough to matter.
    rsk = 3'd1;
    for (int k = 0; k < 800; k++) begin
      ren  = ($urandom_range(0, 24) != 0);
      rclr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) rsk = SW'($urandom_range(0, MS));
      dc  = BW'($urandom);
      n   = hist_c.size();
      src = (rsk == 0) ? dc : hist_at(1, n - int'(rsk));
      de  = src;
      for (int i = 0; i < LN; i++)
        if ($urandom_range(0, 7) == 0) de[i*DW +: DW] = DW'($urandom);
      step(ren, rclr, rsk, dc, de);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/checker_phy_n.md
CHECKER_PHY_N -- requirements
Module: checker_phy_n

Interface
REQ-001 Parameter DATA_W, default 8, width of one lane word.
REQ-002 Parameter LANES, default 2, number of compared lanes (>=1).
REQ-003 Parameter MAX_SKEW, default 7, maximum alignment delay in clk_8f cycles (>=1).
REQ-004 Parameter CNT_W, default 16, width of each per-lane error counter.
REQ-005 Port clk_8f, input, 1, the single clock; all logic rising-edge.
REQ-006 Port reset_L, input, 1, asynchronous active-low reset.
REQ-007 Port enable, input, 1, 1 = checking active.
REQ-008 Port clear, input, 1, synchronous clear of counters, sticky flags and capture.
REQ-009 Port skew, input, $clog2(MAX_SKEW+1), delay applied to the conductual stream.
REQ-010 Port data_c, input, LANES*DATA_W, conductual phy outputs; lane i at [i*DATA_W +: DATA_W].
REQ-011 Port data_e, input, LANES*DATA_W, estructural phy outputs, same packing.
REQ-012 Port check_out, output, LANES, per-lane equality result (1 = match).
REQ-013 Port err_sticky, output, LANES, per-lane latched mismatch flag.
REQ-014 Port err_count, output, LANES*CNT_W, per-lane mismatch counters, same packing.
REQ-015 Port first_err_valid, output, 1, first-mismatch capture holds data.
REQ-016 Port first_err_lane, output, $clog2(LANES) (min 1), lane of first mismatch.
REQ-017 Port first_err_c / first_err_e, output, DATA_W each, compared words of first mismatch.
REQ-018 Port state, output, 2, FSM state: IDLE=0, FILL=1, CHECK=2.

Function
REQ-019 Both inputs SHALL be registered every cycle; the conductual register SHALL feed a MAX_SKEW-deep delay line tapped at skew.
REQ-020 In CHECK, check_out[i] after edge k+1 SHALL equal (data_c lane i sampled at edge k-skew == data_e lane i sampled at edge k).
REQ-021 FSM: IDLE->FILL when enable=1; FILL->CHECK after exactly skew+1 cycles in FILL; any state->IDLE when enable=0.
REQ-022 A change of skew while in FILL or CHECK SHALL return the FSM to FILL and restart the fill count.
REQ-023 In IDLE and FILL, check_out SHALL be all ones and no counter, sticky flag or capture SHALL change.
REQ-024 On a CHECK mismatch on lane i, err_sticky[i] SHALL set and err_count lane i SHALL increment, both on the same edge as check_out[i] falls.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 When first_err_valid=0 and any lane mismatches, capture SHALL record the lowest-index mismatching lane and its two words and set first_err_valid; later mismatches SHALL NOT overwrite it.
REQ-027 clear=1 SHALL zero counters, err_sticky, first_err_* on the next edge and SHALL take priority over a simultaneous mismatch (not counted, not captured); check_out is unaffected by clear.
REQ-028 If skew > MAX_SKEW, the effective skew SHALL be MAX_SKEW.

Reset
REQ-029 While reset_L=0, asynchronously: state=IDLE, check_out all ones, err_sticky=0, err_count=0, first_err_valid=0, first_err_lane=0, first_err_c=0, first_err_e=0, delay line and input registers 0.
REQ-030 Reset asserted mid-FILL or mid-CHECK SHALL discard all history; after release the FSM SHALL restart in IDLE.

Verification
REQ-031 LANES=2, skew=0, enable=1, identical streams 0x00..0xFF -> FILL 1 cycle, then check_out=2'b11, err_count=0 throughout.
REQ-032 skew=3, data_e = data_c delayed 3 cycles -> no mismatch; same stream with skew=2 -> check_out toggles, counts rise on both lanes.
REQ-033 Single corrupted word 0xA5 vs 0x5A on lane 1 in CHECK -> check_out[1]=0 for one cycle, err_sticky[1]=1, count lane 1=1, first_err_lane=1, first_err_c=0xA5, first_err_e=0x5A.
REQ-034 CNT_W=4, continuous mismatch on lane 0 for 20 cycles -> count lane 0 stops at 15.
REQ-035 clear pulsed on a mismatch cycle -> counts, sticky, first_err_valid all 0 next cycle; that mismatch not counted.
REQ-036 reset_L pulsed low between edges in CHECK -> outputs at reset values immediately; after release state=IDLE.
